// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control stage: funct3 encodings,
// FSM states and access decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_RESP
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3[2] || (f3[1:0] == 2'b11);
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: lane mask, split detection, write-data
// positioning and load merge/extension across two memory words.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  n_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rbuf0_i,
    input  logic [31:0] rbuf1_i,
    input  logic [2:0]  funct3_i,
    output logic [7:0]  mask_o,
    output logic        split_o,
    output logic [31:0] wword0_o,
    output logic [31:0] wword1_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  base;
    logic [4:0]  sh;
    logic [63:0] wshift;
    logic [63:0] rshift;

    assign sh = {off_i, 3'b000};

    always_comb begin
        case (n_i)
            3'd1:    base = 8'h01;
            3'd2:    base = 8'h03;
            default: base = 8'h0F;
        endcase
    end

    assign mask_o   = base << off_i;
    assign split_o  = |mask_o[7:4];
    assign wshift   = {32'b0, wdata_i} << sh;
    assign wword0_o = wshift[31:0];
    assign wword1_o = wshift[63:32];
    assign rshift   = {rbuf1_i, rbuf0_i} >> sh;

    always_comb begin
        case (funct3_i)
            F3_LB:   rdata_o = {{24{rshift[7]}}, rshift[7:0]};
            F3_LH:   rdata_o = {{16{rshift[15]}}, rshift[15:0]};
            F3_LBU:  rdata_o = {24'b0, rshift[7:0]};
            F3_LHU:  rdata_o = {16'b0, rshift[15:0]};
            default: rdata_o = rshift[31:0];
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller: one request at a time, misaligned
// accesses split into two word cycles, registered response to writeback.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf0_q, rbuf0_d;
    logic [31:0] rbuf1_q, rbuf1_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        idle;
    logic [1:0]  al_off;
    logic [2:0]  al_f3;
    logic [2:0]  al_n;
    logic [31:0] al_rbuf0, al_rbuf1;
    logic [7:0]  al_mask;
    logic        al_split;
    logic [31:0] al_w0, al_w1, al_rdata;

    assign idle = (state_q == ST_IDLE);

    // In IDLE the aligner decodes the incoming request so the split/error
    // decision is ready at the acceptance edge; otherwise the latched one.
    assign al_off = idle ? req_addr[1:0] : addr_q[1:0];
    assign al_f3  = idle ? req_funct3 : f3_q;
    assign al_n   = size_bytes(al_f3);

    // Forward the word being read this cycle so the extended result can be
    // registered on the same edge that enters RESP.
    assign al_rbuf0 = (state_q == ST_ACC0 && !we_q) ? mem_rdata : rbuf0_q;
    assign al_rbuf1 = (state_q == ST_ACC1 && !we_q) ? mem_rdata : rbuf1_q;

    lsu_lane_align u_align (
        .off_i    (al_off),
        .n_i      (al_n),
        .wdata_i  (wdata_q),
        .rbuf0_i  (al_rbuf0),
        .rbuf1_i  (al_rbuf1),
        .funct3_i (al_f3),
        .mask_o   (al_mask),
        .split_o  (al_split),
        .wword0_o (al_w0),
        .wword1_o (al_w1),
        .rdata_o  (al_rdata)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf0_d    = al_rbuf0;
        rbuf1_d    = al_rbuf1;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (f3_illegal(req_we, req_funct3) || (!ALLOW_MISALIGNED && al_split)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACC0;
                    end
                end
            end
            ST_ACC0: begin
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = al_mask[3:0];
                mem_wdata = al_w0;
                mem_we    = we_q;
                if (al_split) begin
                    state_d = ST_ACC1;
                end else begin
                    rdata_d = we_q ? '0 : al_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_ACC1: begin
                mem_addr  = {addr_q[31:2] + 30'd1, 2'b00};
                mem_be    = al_mask[7:4];
                mem_wdata = al_w1;
                mem_we    = we_q;
                rdata_d   = we_q ? '0 : al_rdata;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf0_q <= '0;
            rbuf1_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf0_q <= rbuf0_d;
            rbuf1_q <= rbuf1_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
